// File: rtl/dsm_pkg.sv
// dsm_pkg: shared widths, constants and helpers for the bitstream modulator
package dsm_pkg;
    localparam int DATA_W          = 24;
    localparam int BYTES_PER_FRAME = 4;
    localparam int ACC_W           = 28;
    localparam int SLOT_W          = $clog2(BYTES_PER_FRAME);

    localparam logic [DATA_W-1:0] MIDSCALE = 24'h800000;
    localparam logic [DATA_W-1:0] CLAMP    = 24'h600000;
    localparam logic [7:0]        PAD_BYTE = 8'h00;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(ACC_W-1) - 1);

    typedef enum logic {HUNT, RX} rx_state_t;

    // Saturate a one-bit-wider intermediate back into the integrator width
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
        return ACC_W'(v > SAT_MAX ? SAT_MAX : v < -SAT_MAX ? -SAT_MAX : v);
    endfunction
endpackage

// File: rtl/dsm_frame_rx.sv
// dsm_frame_rx: reassembles byte-serial frames (MSB first, pad slot last) into samples
module dsm_frame_rx
    import dsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              frame_start,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_stb,
    output logic              locked,
    output logic              frame_err
);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BYTES_PER_FRAME - 1);

    rx_state_t         state;
    logic [SLOT_W-1:0] slot;
    logic [DATA_W-1:0] asm_word;

    // Deframer: bytes shift in MSB first; the pad slot commits the word instead of shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= '0;
            asm_word   <= '0;
            sample_out <= '0;
            sample_stb <= 1'b0;
            locked     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            frame_err  <= 1'b0;
            if (byte_valid) begin
                if (frame_start) begin
                    frame_err <= (state == RX) && (slot != '0);
                    asm_word  <= {asm_word[DATA_W-9:0], byte_in};
                    slot      <= SLOT_W'(1);
                    state     <= RX;
                end else if (state == RX) begin
                    if (slot == '0) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end else if (slot == LAST_SLOT) begin
                        sample_out <= asm_word;
                        sample_stb <= 1'b1;
                        locked     <= 1'b1;
                        frame_err  <= byte_in != PAD_BYTE;
                        slot       <= '0;
                    end else begin
                        asm_word <= {asm_word[DATA_W-9:0], byte_in};
                        slot     <= slot + SLOT_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/dsm_bitstream_modulator.sv
// dsm_bitstream_modulator: deframes samples and regenerates a second-order 1-bit bitstream
module dsm_bitstream_modulator
    import dsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              frame_start,
    output logic              dsm_out,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_stb,
    output logic              locked,
    output logic              frame_err
);
    localparam logic signed [ACC_W:0] XS_LIM = (ACC_W+1)'(CLAMP);
    localparam logic signed [ACC_W:0] FB_MAG = (ACC_W+1)'(MIDSCALE);

    logic [DATA_W-1:0]        held;
    logic [DATA_W-1:0]        xs_raw;
    logic signed [ACC_W:0]    xs_ext, xs, fb, s1, s2;
    logic signed [ACC_W-1:0]  i1, i2, i1_n, i2_n;

    dsm_frame_rx u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .sample_out  (sample_out),
        .sample_stb  (sample_stb),
        .locked      (locked),
        .frame_err   (frame_err)
    );

    // Loop filter: offset binary -> two's complement, clamp, two saturating integrators
    always_comb begin
        xs_raw = {~held[DATA_W-1], held[DATA_W-2:0]};
        xs_ext = {{(ACC_W+1-DATA_W){xs_raw[DATA_W-1]}}, xs_raw};
        xs     = xs_ext > XS_LIM ? XS_LIM : xs_ext < -XS_LIM ? -XS_LIM : xs_ext;
        fb     = dsm_out ? FB_MAG : -FB_MAG;
        s1     = {i1[ACC_W-1], i1} + xs - fb;
        i1_n   = sat(s1);
        s2     = {i2[ACC_W-1], i2} + {i1_n[ACC_W-1], i1_n} - fb;
        i2_n   = sat(s2);
    end

    // Modulator state; a committed sample feeds the loop from the cycle after its strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1      <= '0;
            i2      <= '0;
            dsm_out <= 1'b0;
            held    <= MIDSCALE;
        end else begin
            i1      <= i1_n;
            i2      <= i2_n;
            dsm_out <= ~i2_n[ACC_W-1];
            if (sample_stb) held <= sample_out;
        end
    end
endmodule
